// File: rtl/prio_arbiter_reg.sv
// prio_arbiter_reg
//   Registered N-way priority arbiter with fixed-priority and round-robin modes.
//   A grant is latched into registers and then held until the consumer
//   acknowledges it.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   req        request vector, bit i = source i
//   mode       0 = fixed priority (highest index wins), 1 = round-robin
//   ack        consumer accepts the current grant
//   valid      grant outputs hold a live grant
//   grant_idx  encoded index of the granted source
//   grant_oh   one-hot of grant_idx, all zero while valid=0
//   multi      more than one request was pending when the grant was taken
//   rr_ptr     current round-robin top-priority index
//
// Handshake: a grant is presented while valid=1 and is consumed on any rising
// edge where valid=1 and ack=1. In that same edge a new grant may be taken
// (back-to-back), so valid can stay high. ack while valid=0 has no effect.
// Once presented, grant_idx/grant_oh/multi do not change until consumed.
//
// The FSM state is directly observable: HOLD exactly when valid=1.

module prio_arbiter_reg #(
   parameter int N = 8,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         mode,
   input  logic         ack,
   output logic         valid,
   output logic [W-1:0] grant_idx,
   output logic [N-1:0] grant_oh,
   output logic         multi,
   output logic [W-1:0] rr_ptr
);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   localparam logic [N-1:0] ONE_N   = N'(1);
   localparam logic [W-1:0] TOP_IDX = W'(N - 1);

   state_t       state;
   logic [W-1:0] ack_ptr;     // pointer after the current grant is consumed
   logic [W-1:0] ptr_eff;     // pointer in force for this arbitration
   logic [W-1:0] pick;
   logic [W-1:0] cand_w;
   logic         req_any;
   logic         req_multi;
   logic         consume;
   int           cand;

   assign req_any   = |req;
   // Clearing the lowest set bit leaves something iff two or more bits are set.
   assign req_multi = |(req & (req - ONE_N));
   assign consume   = (state == HOLD) && ack;

   // Granted source drops to lowest priority; wraps modulo N.
   assign ack_ptr = (grant_idx == '0) ? TOP_IDX : (grant_idx - 1'b1);
   // On a consuming edge the re-arbitration already sees the updated pointer.
   assign ptr_eff = consume ? ack_ptr : rr_ptr;

   // Selection: each loop walks from lowest to highest priority so the
   // last hit, i.e. the highest-priority set bit, is the one kept.
   always_comb begin
      pick   = '0;
      cand   = 0;
      cand_w = '0;
      if (!mode) begin
         for (int i = 0; i < N; i++) begin
            if (req[W'(i)]) pick = W'(i);
         end
      end else begin
         // Priority order: ptr, ptr-1, ..., 0, N-1, ..., ptr+1.
         for (int k = N - 1; k >= 0; k--) begin
            cand   = (int'(ptr_eff) - k + N) % N;
            cand_w = W'(cand);
            if (req[cand_w]) pick = cand_w;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         valid     <= 1'b0;
         grant_idx <= '0;
         grant_oh  <= '0;
         multi     <= 1'b0;
         rr_ptr    <= TOP_IDX;
      end else begin
         case (state)
            IDLE: begin
               if (req_any) begin
                  state     <= HOLD;
                  valid     <= 1'b1;
                  grant_idx <= pick;
                  grant_oh  <= ONE_N << pick;
                  multi     <= req_multi;
               end
            end
            HOLD: begin
               if (ack) begin
                  rr_ptr <= ack_ptr;
                  if (req_any) begin
                     grant_idx <= pick;
                     grant_oh  <= ONE_N << pick;
                     multi     <= req_multi;
                  end else begin
                     // grant_idx and multi keep their last values.
                     state    <= IDLE;
                     valid    <= 1'b0;
                     grant_oh <= '0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prio_arbiter_reg.sv
// Directed bench for prio_arbiter_reg (N=8). Inputs change on the falling
// edge, outputs are sampled on the following falling edge.

module tb_prio_arbiter_reg;

   localparam int N = 8;
   localparam int W = 3;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic         mode;
   logic         ack;
   logic         valid;
   logic [W-1:0] grant_idx;
   logic [N-1:0] grant_oh;
   logic         multi;
   logic [W-1:0] rr_ptr;

   always #5 clk = ~clk;

   prio_arbiter_reg #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .mode      (mode),
      .ack       (ack),
      .valid     (valid),
      .grant_idx (grant_idx),
      .grant_oh  (grant_oh),
      .multi     (multi),
      .rr_ptr    (rr_ptr)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [N-1:0] r, input logic m, input logic a);
      req  = r;
      mode = m;
      ack  = a;
   endtask

   // one rising edge, then back to the sampling point
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_grant(input string tag, input logic [W-1:0] idx,
                               input logic m, input logic [W-1:0] ptr);
      check({tag, "_valid"}, 32'(valid), 32'd1);
      check({tag, "_idx"}, 32'(grant_idx), 32'(idx));
      check({tag, "_oh"}, 32'(grant_oh), 32'(8'd1 << idx));
      check({tag, "_multi"}, 32'(multi), 32'(m));
      check({tag, "_ptr"}, 32'(rr_ptr), 32'(ptr));
   endtask

   task automatic expect_idle(input string tag, input logic [W-1:0] ptr);
      check({tag, "_valid"}, 32'(valid), 32'd0);
      check({tag, "_oh"}, 32'(grant_oh), 32'd0);
      check({tag, "_ptr"}, 32'(rr_ptr), 32'(ptr));
   endtask

   // ---------------- stimulus ----------------
   logic [W-1:0] rr_seq [8];

   initial begin
      rr_seq = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
      rst = 1'b1;
      drive(8'h00, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      expect_idle("rst", 3'd7);
      check("rst_idx", 32'(grant_idx), 32'd0);
      check("rst_multi", 32'(multi), 32'd0);
      rst = 1'b0;

      // fixed priority with three requests
      drive(8'h26, 1'b0, 1'b0);
      step();
      expect_grant("fix", 3'd5, 1'b1, 3'd7);
      drive(8'h01, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         expect_grant("fix_hold", 3'd5, 1'b1, 3'd7);
      end

      // asynchronous reset in the middle of a held grant
      rst = 1'b1;
      #1;
      expect_idle("arst", 3'd7);
      @(negedge clk);
      rst = 1'b0;
      drive(8'h00, 1'b0, 1'b0);
      step();
      expect_idle("arst_rel", 3'd7);

      // single request, then release to idle
      drive(8'h01, 1'b0, 1'b0);
      step();
      expect_grant("single", 3'd0, 1'b0, 3'd7);
      drive(8'h00, 1'b0, 1'b1);
      step();
      expect_idle("single_ack", 3'd7);
      check("single_keep_idx", 32'(grant_idx), 32'd0);

      // round-robin fairness, all requesting, ack held
      drive(8'hFF, 1'b1, 1'b0);
      step();
      expect_grant("rr_first", 3'd7, 1'b1, 3'd7);
      ack = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check("rr_valid", 32'(valid), 32'd1);
         check("rr_idx", 32'(grant_idx), 32'(rr_seq[i]));
      end
      check("rr_ptr_end", 32'(rr_ptr), 32'd7);
      drive(8'h00, 1'b1, 1'b1);
      step();
      expect_idle("rr_drain", 3'd6);

      // steer pointer to 1 via a grant of 2
      drive(8'h04, 1'b1, 1'b0);
      step();
      expect_grant("set_p1", 3'd2, 1'b0, 3'd6);
      drive(8'h00, 1'b1, 1'b1);
      step();
      expect_idle("set_p1_ack", 3'd1);

      // round-robin wrap: pointer 1 searches 1,0,7
      drive(8'h84, 1'b1, 1'b0);
      step();
      expect_grant("wrap", 3'd7, 1'b1, 3'd1);
      ack = 1'b1;
      step();
      expect_grant("wrap_next", 3'd2, 1'b1, 3'd6);
      drive(8'h00, 1'b1, 1'b1);
      step();
      expect_idle("wrap_drain", 3'd1);

      // steer pointer to 3 via a grant of 4
      drive(8'h10, 1'b1, 1'b0);
      step();
      expect_grant("set_p3", 3'd4, 1'b0, 3'd1);
      drive(8'h00, 1'b1, 1'b1);
      step();
      expect_idle("set_p3_ack", 3'd3);

      // mode switch between back-to-back grants
      drive(8'h90, 1'b1, 1'b0);
      step();
      expect_grant("msw_rr", 3'd7, 1'b1, 3'd3);
      drive(8'h90, 1'b0, 1'b1);
      step();
      expect_grant("msw_fix", 3'd7, 1'b1, 3'd6);

      // ack while idle must not move the pointer
      drive(8'h00, 1'b0, 1'b1);
      step();
      expect_idle("idle_ack1", 3'd6);
      step();
      expect_idle("idle_ack2", 3'd6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prio_arbiter_reg.md
Name: prio_arbiter_reg

Overview:
Parametrised, registered priority encoder/arbiter. It generalises the 4-to-2 combinational encoder to N request lines and adds a selectable round-robin mode. The encoded grant is latched and held under a valid/ack handshake. It sits between a bank of request sources and a single shared consumer, which acknowledges each grant.

Parameters:
N, 8, number of request lines (N >= 2)
W, $clog2(N), width of encoded grant index (derived; not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  N  request vector; bit i = request from source i
mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin
ack  input  1  consumer accepts current grant; meaningful only while valid=1
valid  output  1  grant outputs hold a live grant
grant_idx  output  W  encoded index of granted source
grant_oh  output  N  one-hot of grant_idx; all zero when valid=0
multi  output  1  more than one req bit was set when the current grant was taken
rr_ptr  output  W  current round-robin top-priority index (debug/observability)

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (async, any time including mid-grant):
  - valid=0, grant_idx=0, grant_oh=0, multi=0.
  - rr_ptr=N-1, so round-robin starts out identical to fixed priority.
  - FSM goes to IDLE.
- FSM has two states, IDLE and HOLD.
- IDLE:
  - Each rising edge samples req.
  - If req != 0: latch grant, set valid=1, go to HOLD. Latency is 1 cycle: req set before edge k gives valid=1 after edge k.
  - If req == 0: stay in IDLE, outputs unchanged (valid=0, grant_oh=0).
- Grant selection:
  - Sampled at the arbitration edge, using mode, req and the pointer in force.
  - mode=0: the highest set index wins, independent of rr_ptr. This is the MSB-first priority of the existing encoder.
  - mode=1: priority order is rr_ptr, rr_ptr-1, ..., 0, N-1, ..., rr_ptr+1 (wrapping). The first set bit in that order wins.
  - multi=1 iff popcount(req) >= 2 at the arbitration edge.
- HOLD:
  - grant_idx, grant_oh and multi are frozen.
  - Deasserting the granted req bit does not revoke the grant.
  - Changes to mode or req have no effect until the next arbitration.
  - ack=0: remain in HOLD.
  - ack=1 at an edge, step 1: rr_ptr <= (grant_idx - 1) mod N, in both modes. Granted source becomes lowest priority; grant_idx=0 gives rr_ptr=N-1.
  - ack=1 at an edge, step 2: if req != 0 at that same edge, re-arbitrate immediately using the updated pointer. Stay in HOLD with valid=1 (back-to-back grant, no bubble).
  - ack=1 at an edge, step 3: if req == 0, go to IDLE with valid=0 and grant_oh=0. grant_idx keeps its last value.
- ack while valid=0 is ignored (no pointer update).
- Throughput: one grant per cycle maximum with ack held high.
- Invariant: grant_oh == (1 << grant_idx) whenever valid=1.
- Width rules:
  - Index arithmetic is modulo N, including for non-power-of-2 N.
  - grant_idx never exceeds N-1.

Test Plan:
- Reset: assert rst mid-HOLD with grant_idx=5 -> same cycle (asynchronously) valid=0, grant_oh=0, rr_ptr=7. After release, req=0 keeps valid=0.
- Fixed priority, mode=0: req=8'b0010_0110 -> next edge valid=1, grant_idx=5, grant_oh=8'h20, multi=1. Hold ack=0 for 3 cycles while changing req to 8'h01 -> outputs unchanged.
- Single request, mode=0: req=8'h01 -> grant_idx=0, multi=0. ack=1 with req=0 -> valid=0 next edge, rr_ptr=7.
- Round-robin fairness, mode=1: req=8'hFF held, ack=1 continuously -> grant_idx sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles, valid stays 1.
- Round-robin skip/wrap, mode=1: rr_ptr=1 and req=8'b1000_0100 -> grant_idx=7 (search 1,0,7). After ack, rr_ptr=6 and next grant is 2.
- Mode switch: with rr_ptr=3, req=8'h90, mode=1 -> grant 7. After ack, with mode=0, req=8'h90 -> grant 7 again (fixed ignores rr_ptr), and rr_ptr=6.
